// File: rtl/ram_ws_ctrl.sv
// ram_ws_ctrl: byte-serial 256x8 data memory with programmable wait states and MOV/MOC handshake
module ram_ws_ctrl #(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH = 256
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MOV,
  input  logic        RW,
  input  logic [2:0]  MS,
  input  logic [31:0] ADDR,
  input  logic [31:0] DATA_IN,
  output logic [31:0] DATA_OUT,
  output logic        MOC,
  output logic        ERR
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_t;
  state_t state, state_nx;
  logic [7:0] memory [DEPTH];
  logic [AW-1:0] addr;
  logic [31:0] sh;
  logic rw;
  logic [2:0] ms;
  logic [2:0] n;
  logic [2:0] k;
  logic [CW-1:0] wcnt;
  logic err;
  logic [2:0] req_n;
  logic req_ok;
  logic last;
  logic [AW-1:0] idx;
  logic [31:0] full;
  logic [31:0] ext;
  // Request decode, current byte address and big-endian read assembly
  always_comb begin
    req_n = MS[1] ? 3'd4 : MS[0] ? 3'd2 : 3'd1;
    req_ok = (MS != 3'b011) && (MS[2:1] != 2'b11) &&
             !(MS[1:0] == 2'b01 && ADDR[0]) &&
             !(MS[1:0] == 2'b10 && ADDR[1:0] != 2'b00) &&
             ({1'b0, ADDR} + 33'(req_n) - 33'd1 < 33'(DEPTH));
    last = (k == n - 3'd1);
    idx = addr + AW'(k);
    full = {sh[23:0], memory[idx]};
    ext = (ms == 3'b100) ? {{24{full[7]}}, full[7:0]} :
          (ms == 3'b101) ? {{16{full[15]}}, full[15:0]} : full;
  end
  // Next-state: invalid requests skip straight to DONE with ERR
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (MOV) state_nx = !req_ok ? DONE : (WAIT_CYCLES == 0 ? XFER : WAIT);
      WAIT: if (int'(wcnt) == WAIT_CYCLES - 1) state_nx = XFER;
      XFER: if (last) state_nx = DONE;
      DONE: if (!MOV) state_nx = IDLE;
    endcase
  end
  // State register
  always_ff @(posedge CLK) begin
    if (!RESET) state <= IDLE;
    else state <= state_nx;
  end
  // Request capture, wait counter, byte shifter and read result
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      DATA_OUT <= '0;
      err <= 1'b0;
      wcnt <= '0;
      k <= '0;
    end else begin
      if (state == IDLE && MOV) begin
        addr <= ADDR[AW-1:0];
        rw <= RW;
        ms <= MS;
        n <= req_n;
        k <= '0;
        wcnt <= '0;
        err <= !req_ok;
        sh <= RW ? 32'd0 : req_n == 3'd4 ? DATA_IN :
              req_n == 3'd2 ? {DATA_IN[15:0], 16'd0} : {DATA_IN[7:0], 24'd0};
      end
      if (state == WAIT) wcnt <= wcnt + CW'(1);
      if (state == XFER) begin
        k <= k + 3'd1;
        sh <= rw ? full : {sh[23:0], 8'd0};
        if (last && rw) DATA_OUT <= ext;
      end
      if (state == DONE && !MOV) err <= 1'b0;
    end
  end
  // Memory write port: most significant pending byte goes out first; never reset
  always_ff @(posedge CLK) begin
    if (RESET && state == XFER && !rw) memory[idx] <= sh[31:24];
  end
  assign MOC = (state == DONE);
  assign ERR = err;
endmodule

// File: doc/ram_ws_ctrl.md
# ram_ws_ctrl

Byte-organised 256×8 data memory with a programmable-wait-state controller that serves the datapath's MOV/MOC handshake. It sits directly downstream of the datapath's MAR/MDR, R/W and size (MS) signals. It returns read data to the IR/MDR path on DATA_OUT. Accesses are byte-serial: one memory byte per clock after the wait states, assembled big-endian, with size, alignment and range checking.

## Interface
- WAIT_CYCLES, 2: idle cycles inserted between request capture and the first byte transfer (0 allowed).
- DEPTH, 256: number of bytes in the internal array `memory` (byte-wide, hierarchically preloadable by benches).
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-low reset.
- MOV  in  1  memory operation valid (request).
- RW  in  1  1 = read, 0 = write.
- MS  in  3  size: 000 unsigned byte, 001 unsigned halfword, 010 word, 100 signed byte, 101 signed halfword; 011/110/111 reserved.
- ADDR  in  32  byte address.
- DATA_IN  in  32  write data, right-justified.
- DATA_OUT  out  32  read data, right-justified, extended per MS.
- MOC  out  1  memory operation complete.
- ERR  out  1  request rejected (valid only while MOC=1).

## Operation
- States: IDLE, WAIT, XFER, DONE.
- IDLE: on an edge with MOV=1, latch ADDR, RW, MS, DATA_IN; set byte count n (1/2/4).
  - If the request is valid: go to WAIT, or straight to XFER when WAIT_CYCLES=0.
  - If invalid: go to DONE with ERR=1; no memory access.
- Invalid request: reserved MS; halfword with ADDR[0]≠0; word with ADDR[1:0]≠0; ADDR+n−1 ≥ DEPTH.
- WAIT: counter runs WAIT_CYCLES edges, then go to XFER.
- XFER: one byte per edge at address A+k, k=0..n−1, big-endian (byte at A is most significant).
  - Write: memory[A+k] = DATA_IN byte (n−1−k). Example, word: memory[A] = DATA_IN[31:24] … memory[A+3] = DATA_IN[7:0].
  - Read: shift each byte into a 32-bit assembly register.
  - After the last byte, go to DONE with MOC=1.
- DONE, read: DATA_OUT is loaded on DONE entry. It is zero-extended for 000/001/010 and sign-extended from bit 7 (100) or bit 15 (101).
- DONE, write: DATA_OUT keeps its previous value. Signed size codes behave as the unsigned size.
- DONE: MOC held at 1 (and ERR held) until an edge samples MOV=0. At that edge, MOC=0, ERR=0 and the state returns to IDLE. Four-phase handshake: a new request needs MOV to return low first.
- MOV falling during WAIT/XFER is ignored. The access always completes, then MOC is high for exactly one cycle if MOV is still 0.
- Memory contents are never reset.

## Timing
- Reset: the state goes to IDLE and MOC=0, ERR=0, DATA_OUT=0 on the first edge with RESET=0. Reset overrides MOV.
- Reset mid-access aborts the access. Bytes already written stay written; remaining bytes are untouched.
- Latency is counted with edge 0 as the one sampling MOV=1 in IDLE.
  - Valid access: MOC rises after edge WAIT_CYCLES+n. With the default of 2: byte after edge 3, halfword after edge 4, word after edge 6.
  - Invalid access: MOC and ERR rise after edge 0.
- Memory write of byte k becomes visible after edge WAIT_CYCLES+1+k.
- DATA_OUT is stable from the MOC rise until the next read completes.
- MOC falls after the first edge in DONE that samples MOV=0. Minimum MOC high time is one cycle.

## Test plan
- Reset: hold RESET=0 for 2 edges with MOV=1 and RW=0 -> MOC=0, ERR=0, DATA_OUT=0; memory unchanged.
- Word write/read, WAIT_CYCLES=2:
  - Write 0xDEADBEEF to 0x10 -> MOC after edge 6; memory[0x10..0x13] = DE, AD, BE, EF.
  - Read word at 0x10 -> DATA_OUT = 0xDEADBEEF.
- Extension, after the word write above:
  - MS=000 at 0x12 -> 0x000000BE.
  - MS=100 at 0x12 -> 0xFFFFFFBE.
  - MS=101 at 0x12 -> 0xFFFFBEEF.
  - MS=001 at 0x10 -> 0x0000DEAD.
- Errors -> MOC=1 and ERR=1 after edge 0, memory unchanged:
  - Word at 0x11.
  - Halfword at 0xFF.
  - Byte at 0x100.
  - MS=011.
- Handshake:
  - Hold MOV=1 for 3 cycles past MOC -> MOC stays 1, no second access; drop MOV -> MOC=0 after the next edge.
  - One-cycle MOV pulse for a byte read -> completes; MOC high exactly one cycle.
- Mid-op reset: word write of 0x11223344 to 0x20 with RESET=0 after edge 4 -> IDLE, MOC=0; memory[0x20..0x21] = 11, 22; memory[0x22..0x23] keep prior contents.
